// File: rtl/duck_round_ctrl.sv
// Round sequencer for the duck-hunt game: runs each bird's launch/flight/fall/escape
// life cycle and tracks shots, hits, birds and the round number.
module duck_round_ctrl #(
    parameter int BIRDS_PER_ROUND = 3,
    parameter int SHOTS_PER_BIRD  = 3,
    parameter int MIN_HITS        = 2,
    parameter int FLY_FRAMES      = 600,
    parameter int FALL_FRAMES     = 60,
    parameter int PAUSE_FRAMES    = 120
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       trigger,
    input  logic       bird_hit,
    input  logic       bird_offscreen,
    output logic [1:0] game_state,
    output logic       launch,
    output logic       flew_away,
    output logic       bird_falling,
    output logic [1:0] shots_left,
    output logic [1:0] birds_done,
    output logic [1:0] hits,
    output logic [7:0] round,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_FLYING    = 3'd2,
        S_FALLING   = 3'd3,
        S_ESCAPING  = 3'd4,
        S_BIRD_DONE = 3'd5,
        S_ROUND_END = 3'd6,
        S_GAME_OVER = 3'd7
    } state_t;

    localparam logic [9:0] FLY_LIM   = 10'(FLY_FRAMES);
    localparam logic [9:0] FALL_LIM  = 10'(FALL_FRAMES);
    localparam logic [9:0] PAUSE_LIM = 10'(PAUSE_FRAMES);
    localparam logic [1:0] SHOTS_INI = 2'(SHOTS_PER_BIRD);
    localparam logic [1:0] BIRDS_LIM = 2'(BIRDS_PER_ROUND);
    localparam logic [1:0] HITS_MIN  = 2'(MIN_HITS);

    state_t     state_q, state_d;
    logic [9:0] frame_cnt_q, frame_cnt_d;
    logic [1:0] shots_left_q, shots_left_d;
    logic [1:0] birds_done_q, birds_done_d;
    logic [1:0] hits_q, hits_d;
    logic [7:0] round_q, round_d;
    logic       trigger_q, trigger_d;
    logic       shot_s;
    logic [9:0] frame_inc_s;

    assign shot_s      = trigger & ~trigger_q;
    assign frame_inc_s = frame_cnt_q + 10'd1;

    // Next-state and counter updates; frame counter is shared by the timed states.
    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        shots_left_d = shots_left_q;
        birds_done_d = birds_done_q;
        hits_d       = hits_q;
        round_d      = round_q;
        trigger_d    = trigger;
        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start) begin
                    round_d      = 8'd1;
                    hits_d       = 2'd0;
                    birds_done_d = 2'd0;
                    state_d      = S_LAUNCH;
                end else begin
                    state_d = state_q;
                end
            end
            S_LAUNCH: begin
                shots_left_d = SHOTS_INI;
                frame_cnt_d  = 10'd0;
                state_d      = S_FLYING;
            end
            S_FLYING: begin
                // A valid shot takes priority over the flight timeout.
                if (shot_s && (shots_left_q != 2'd0)) begin
                    shots_left_d = shots_left_q - 2'd1;
                    if (bird_hit) begin
                        hits_d      = hits_q + 2'd1;
                        frame_cnt_d = 10'd0;
                        state_d     = S_FALLING;
                    end else if (shots_left_q == 2'd1) begin
                        state_d = S_ESCAPING;
                    end else begin
                        state_d = S_FLYING;
                    end
                end else if (frame_tick) begin
                    frame_cnt_d = frame_inc_s;
                    if (frame_inc_s == FLY_LIM) begin
                        state_d = S_ESCAPING;
                    end else begin
                        state_d = S_FLYING;
                    end
                end else begin
                    state_d = S_FLYING;
                end
            end
            S_FALLING: begin
                if (frame_tick) begin
                    frame_cnt_d = frame_inc_s;
                    if (frame_inc_s == FALL_LIM) begin
                        state_d = S_BIRD_DONE;
                    end else begin
                        state_d = S_FALLING;
                    end
                end else begin
                    state_d = S_FALLING;
                end
            end
            S_ESCAPING: begin
                if (bird_offscreen) begin
                    state_d = S_BIRD_DONE;
                end else begin
                    state_d = S_ESCAPING;
                end
            end
            S_BIRD_DONE: begin
                birds_done_d = birds_done_q + 2'd1;
                if ((birds_done_q + 2'd1) == BIRDS_LIM) begin
                    frame_cnt_d = 10'd0;
                    state_d     = S_ROUND_END;
                end else begin
                    state_d = S_LAUNCH;
                end
            end
            S_ROUND_END: begin
                if (frame_tick) begin
                    frame_cnt_d = frame_inc_s;
                    if (frame_inc_s != PAUSE_LIM) begin
                        state_d = S_ROUND_END;
                    end else if (hits_q >= HITS_MIN) begin
                        round_d      = (round_q == 8'd255) ? round_q : round_q + 8'd1;
                        hits_d       = 2'd0;
                        birds_done_d = 2'd0;
                        state_d      = S_LAUNCH;
                    end else begin
                        // Counters held so the final score stays on screen.
                        state_d = S_GAME_OVER;
                    end
                end else begin
                    state_d = S_ROUND_END;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            frame_cnt_q  <= 10'd0;
            shots_left_q <= 2'd0;
            birds_done_q <= 2'd0;
            hits_q       <= 2'd0;
            round_q      <= 8'd0;
            trigger_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            shots_left_q <= shots_left_d;
            birds_done_q <= birds_done_d;
            hits_q       <= hits_d;
            round_q      <= round_d;
            trigger_q    <= trigger_d;
        end
    end

    // Moore output decode from the state register.
    always_comb begin
        game_state = 2'd1;
        case (state_q)
            S_IDLE:      game_state = 2'd0;
            S_ROUND_END: game_state = 2'd2;
            S_GAME_OVER: game_state = 2'd3;
            default:     game_state = 2'd1;
        endcase
    end

    assign launch       = (state_q == S_LAUNCH);
    assign flew_away    = (state_q == S_ESCAPING);
    assign bird_falling = (state_q == S_FALLING);
    assign game_over    = (state_q == S_GAME_OVER);
    assign shots_left   = shots_left_q;
    assign birds_done   = birds_done_q;
    assign hits         = hits_q;
    assign round        = round_q;

endmodule

// File: tb/tb_duck_round_ctrl.sv
// Directed self-checking bench for duck_round_ctrl with default parameters.
module tb_duck_round_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick, start, trigger, bird_hit, bird_offscreen;
    logic [1:0] game_state, shots_left, birds_done, hits;
    logic       launch, flew_away, bird_falling, game_over;
    logic [7:0] round;

    int n_checks = 0;
    int n_errors = 0;
    int launch_cnt = 0;
    int launch_base;

    duck_round_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start),
        .trigger(trigger), .bird_hit(bird_hit), .bird_offscreen(bird_offscreen),
        .game_state(game_state), .launch(launch), .flew_away(flew_away),
        .bird_falling(bird_falling), .shots_left(shots_left), .birds_done(birds_done),
        .hits(hits), .round(round), .game_over(game_over)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (launch) launch_cnt <= launch_cnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // From LAUNCH: fly, hit on the first shot, fall 60 frames, leave BIRD_DONE.
    task automatic hit_bird();
        step(1);
        trigger = 1'b1; bird_hit = 1'b1;
        step(1);
        trigger = 1'b0; bird_hit = 1'b0;
        frame_tick = 1'b1;
        step(60);
        frame_tick = 1'b0;
        step(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gs"}, int'(game_state), 0);
        check({tag, "_launch"}, int'(launch), 0);
        check({tag, "_flew"}, int'(flew_away), 0);
        check({tag, "_fall"}, int'(bird_falling), 0);
        check({tag, "_go"}, int'(game_over), 0);
        check({tag, "_shots"}, int'(shots_left), 0);
        check({tag, "_birds"}, int'(birds_done), 0);
        check({tag, "_hits"}, int'(hits), 0);
        check({tag, "_round"}, int'(round), 0);
    endtask

    initial begin
        Reset = 1'b1; frame_tick = 1'b0; start = 1'b0;
        trigger = 1'b0; bird_hit = 1'b0; bird_offscreen = 1'b0;
        step(2);
        check_reset_outputs("rst");
        Reset = 1'b0;
        step(2);
        check("idle_gs", int'(game_state), 0);

        // Perfect round
        launch_base = launch_cnt;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("start_round", int'(round), 1);
        check("start_launch", int'(launch), 1);
        check("start_gs", int'(game_state), 1);
        step(1);
        check("fly_shots", int'(shots_left), 3);
        trigger = 1'b1; bird_hit = 1'b1;
        step(1);
        trigger = 1'b0; bird_hit = 1'b0;
        check("hit1_fall", int'(bird_falling), 1);
        check("hit1_shots", int'(shots_left), 2);
        check("hit1_hits", int'(hits), 1);
        frame_tick = 1'b1;
        step(59);
        check("fall_59", int'(bird_falling), 1);
        step(1);
        frame_tick = 1'b0;
        check("fall_60", int'(bird_falling), 0);
        check("bd_birds", int'(birds_done), 0);
        step(1);
        check("bd_next_birds", int'(birds_done), 1);
        check("bd_next_launch", int'(launch), 1);
        hit_bird();
        hit_bird();
        check("pr_gs", int'(game_state), 2);
        check("pr_hits", int'(hits), 3);
        check("pr_birds", int'(birds_done), 3);
        check("pr_launches", launch_cnt - launch_base, 3);
        frame_tick = 1'b1;
        step(119);
        check("pause_119", int'(game_state), 2);
        step(1);
        frame_tick = 1'b0;
        check("r2_round", int'(round), 2);
        check("r2_hits", int'(hits), 0);
        check("r2_birds", int'(birds_done), 0);
        check("r2_launch", int'(launch), 1);

        // Miss-out on bird 1 of round 2
        step(1);
        check("mo_shots0", int'(shots_left), 3);
        for (int i = 0; i < 3; i++) begin
            trigger = 1'b1; bird_hit = 1'b0;
            step(1);
            trigger = 1'b0;
            check("mo_shots", int'(shots_left), 2 - i);
            check("mo_flew", int'(flew_away), (i == 2) ? 1 : 0);
            step(1);
        end
        check("mo_hits", int'(hits), 0);
        bird_offscreen = 1'b1;
        step(1);
        bird_offscreen = 1'b0;
        check("mo_off_flew", int'(flew_away), 0);
        step(1);
        check("mo_birds", int'(birds_done), 1);
        check("mo_launch", int'(launch), 1);

        // Timeout on bird 2
        step(1);
        frame_tick = 1'b1;
        step(599);
        check("to_599", int'(flew_away), 0);
        step(1);
        frame_tick = 1'b0;
        check("to_600", int'(flew_away), 1);
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        check("esc_shot_ign", int'(shots_left), 3);
        check("esc_still", int'(flew_away), 1);
        step(1);
        bird_offscreen = 1'b1;
        step(1);
        bird_offscreen = 1'b0;
        step(1);
        check("to_birds", int'(birds_done), 2);

        // Bird 3: hit and timeout on the same edge
        step(1);
        frame_tick = 1'b1;
        step(599);
        trigger = 1'b1; bird_hit = 1'b1;
        step(1);
        trigger = 1'b0; bird_hit = 1'b0;
        check("col_fall", int'(bird_falling), 1);
        check("col_flew", int'(flew_away), 0);
        check("col_hits", int'(hits), 1);
        step(60);
        frame_tick = 1'b0;
        step(1);
        check("r2_end_gs", int'(game_state), 2);

        // Game over: only 1 hit in round 2
        frame_tick = 1'b1;
        step(120);
        frame_tick = 1'b0;
        check("go_gs", int'(game_state), 3);
        check("go_flag", int'(game_over), 1);
        step(3);
        check("go_round", int'(round), 2);
        check("go_hits", int'(hits), 1);
        check("go_birds", int'(birds_done), 3);
        launch_base = launch_cnt;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("rs_round", int'(round), 1);
        check("rs_hits", int'(hits), 0);
        check("rs_go", int'(game_over), 0);
        step(5);
        check("rs_launches", launch_cnt - launch_base, 1);

        // Trigger held for 50 cycles
        trigger = 1'b1; bird_hit = 1'b0;
        step(50);
        check("hold_shots", int'(shots_left), 2);
        check("hold_gs", int'(game_state), 1);
        check("hold_flew", int'(flew_away), 0);
        trigger = 1'b0;
        step(1);

        // Asynchronous reset while falling
        trigger = 1'b1; bird_hit = 1'b1;
        step(1);
        trigger = 1'b0; bird_hit = 1'b0;
        check("ar_fall", int'(bird_falling), 1);
        #2;
        Reset = 1'b1;
        #1;
        check_reset_outputs("arst");
        step(1);
        Reset = 1'b0;
        launch_base = launch_cnt;
        step(3);
        check("post_rst_gs", int'(game_state), 0);
        check("post_rst_launches", launch_cnt - launch_base, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
